// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default widths and Gray/binary pointer conversions.
// Conversions work on 32-bit values; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

   localparam int FIFO_DW = 8;
   localparam int FIFO_AW = 4;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
// Latency 2 clk cycles; no flow control, samples every cycle.
module ptr_sync_2ff #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1 <= '0;
         q  <= '0;
      end else begin
         q1 <= d;
         q  <= q1;
      end
   end

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Async FIFO write controller: zero-latency memory write on accept, pushes dropped and flagged while full.
// Build option FIFO_WR_OVF_CNT_EN adds a saturating 8-bit dropped-push counter (ovf_count).
module async_fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int DW        = FIFO_DW,
   parameter int AW        = FIFO_AW,
   parameter int AF_MARGIN = 2
) (
   input  logic          wr_clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_wr_addr,
   output logic [DW-1:0] mem_din,
   input  logic [AW:0]   rd_ptr_gray,
   output logic [AW:0]   wr_ptr_gray,
   output logic          full,
   output logic          almost_full,
   output logic [AW:0]   wr_level,
`ifdef FIFO_WR_OVF_CNT_EN
   output logic [7:0]    ovf_count,
`endif
   output logic          ovf
);

   localparam int          PW       = AW + 1;
   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

   logic          acc;
   logic [AW:0]   wr_bin;
   logic [AW:0]   bin_next;
   logic [AW:0]   gray_next;
   logic [AW:0]   rq2;
   logic [AW:0]   rq2_bin;
   logic [AW:0]   level_next;

   ptr_sync_2ff #(.W(PW)) u_rd_ptr_sync (
      .clk (wr_clk),
      .rst (rst),
      .d   (rd_ptr_gray),
      .q   (rq2)
   );

   assign acc         = push & ~full;
   assign mem_wr_en   = acc;
   assign mem_wr_addr = wr_bin[AW-1:0];
   assign mem_din     = push_data;

   assign bin_next   = wr_bin + {{AW{1'b0}}, acc};
   assign gray_next  = PW'(bin2gray(32'(bin_next)));
   assign rq2_bin    = PW'(gray2bin(32'(rq2)));
   // Level is measured against the lagging synced read pointer, so it only ever over-reports.
   assign level_next = bin_next - rq2_bin;

   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         wr_bin      <= '0;
         wr_ptr_gray <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wr_level    <= '0;
         ovf         <= 1'b0;
      end else begin
         wr_bin      <= bin_next;
         wr_ptr_gray <= gray_next;
         full        <= (gray_next == {~rq2[AW:AW-1], rq2[AW-2:0]});
         almost_full <= (level_next >= AF_LEVEL);
         wr_level    <= level_next;
         if (push && full) begin
            ovf <= 1'b1;
         end
      end
   end

`ifdef FIFO_WR_OVF_CNT_EN
   always_ff @(posedge wr_clk or posedge rst) begin
      if (rst) begin
         ovf_count <= '0;
      end else if (push && full && (ovf_count != 8'hFF)) begin
         ovf_count <= ovf_count + 8'd1;
      end
   end
`endif

endmodule
